// File: rtl/interrupt_source_conditioner.sv
// Per-line interrupt conditioning (synchronise, edge/level detect, pending, mask) ahead of the priority controller.
// Optional two-flop input synchroniser enabled by defining INTR_SYNC_EN.
module interrupt_source_conditioner #(
    parameter int NO_OF_PERIPHERALS = 8,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [1:0]                   paddr,
    input  logic [NO_OF_PERIPHERALS-1:0] pwdata,
    output logic [NO_OF_PERIPHERALS-1:0] prdata,
    output logic                         pready,
    input  logic [NO_OF_PERIPHERALS-1:0] irq_in,
    output logic [NO_OF_PERIPHERALS-1:0] interrupt_active,
    input  logic                         interrupt_valid,
    input  logic [WIDTH-1:0]             interrupt_to_be_service,
    input  logic                         interrupt_serviced
);

    localparam int N = NO_OF_PERIPHERALS;

    logic [N-1:0] mask_q, mode_q, pend_q, pend_d;
    logic [N-1:0] sync_q, sync_d_q, rise;
    logic [N-1:0] svc_clr, wr_clr, to_edge;
    logic [N-1:0] prdata_q;
    logic         pready_q;
    logic         wr_en;

`ifdef INTR_SYNC_EN
    logic [N-1:0] meta_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            meta_q   <= '0;
            sync_q   <= '0;
            sync_d_q <= '0;
        end else begin
            meta_q   <= irq_in;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
        end
    end
`else
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q   <= '0;
            sync_d_q <= '0;
        end else begin
            sync_q   <= irq_in;
            sync_d_q <= sync_q;
        end
    end
`endif

    assign rise  = sync_q & ~sync_d_q;
    assign wr_en = penable & pwrite;

    always_comb begin
        svc_clr = '0;
        if (interrupt_serviced && interrupt_valid) begin
            for (int i = 0; i < N; i++) begin
                if (int'(interrupt_to_be_service) == i) svc_clr[i] = 1'b1;
            end
        end
        wr_clr  = (wr_en && paddr == 2'd2) ? pwdata : '0;
        to_edge = (wr_en && paddr == 2'd1) ? (pwdata & ~mode_q) : '0;
        pend_d  = '0;
        // Level bits track the line; a bit switching to edge starts from a clean slate.
        for (int i = 0; i < N; i++) begin
            if (!mode_q[i])
                pend_d[i] = to_edge[i] ? rise[i] : sync_q[i];
            else
                pend_d[i] = rise[i] | (pend_q[i] & ~(svc_clr[i] | wr_clr[i]));
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mask_q   <= '0;
            mode_q   <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else if (penable) begin
            pready_q <= 1'b1;
            if (pwrite) begin
                case (paddr)
                    2'd0:    mask_q <= pwdata;
                    2'd1:    mode_q <= pwdata;
                    default: ;
                endcase
            end else begin
                case (paddr)
                    2'd0:    prdata_q <= mask_q;
                    2'd1:    prdata_q <= mode_q;
                    2'd2:    prdata_q <= pend_q;
                    default: prdata_q <= sync_q;
                endcase
            end
        end else begin
            pready_q <= 1'b0;
        end
    end

    assign prdata           = prdata_q;
    assign pready           = pready_q;
    assign interrupt_active = pend_q & mask_q;

endmodule

// File: tb/tb_interrupt_source_conditioner.sv
// Directed bench for interrupt_source_conditioner; latency follows the INTR_SYNC_EN build option.
module tb_interrupt_source_conditioner;

`ifdef INTR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       pclk = 1'b0;
    logic       presetn;
    logic       penable;
    logic       pwrite;
    logic [1:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic [7:0] irq_in;
    logic [7:0] interrupt_active;
    logic       interrupt_valid;
    logic [2:0] interrupt_to_be_service;
    logic       interrupt_serviced;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    interrupt_source_conditioner #(.NO_OF_PERIPHERALS(8)) dut (
        .pclk                    (pclk),
        .presetn                 (presetn),
        .penable                 (penable),
        .pwrite                  (pwrite),
        .paddr                   (paddr),
        .pwdata                  (pwdata),
        .prdata                  (prdata),
        .pready                  (pready),
        .irq_in                  (irq_in),
        .interrupt_active        (interrupt_active),
        .interrupt_valid         (interrupt_valid),
        .interrupt_to_be_service (interrupt_to_be_service),
        .interrupt_serviced      (interrupt_serviced)
    );

    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
        penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
        tick(1);
        penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [7:0] d);
        penable = 1'b1; pwrite = 1'b0; paddr = a;
        tick(1);
        d = prdata;
        penable = 1'b0;
    endtask

    task automatic service(input logic [2:0] idx);
        interrupt_valid = 1'b1; interrupt_serviced = 1'b1; interrupt_to_be_service = idx;
    endtask

    task automatic service_off();
        interrupt_valid = 1'b0; interrupt_serviced = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        irq_in = 8'hFF; service_off(); interrupt_to_be_service = '0;
        #2 presetn = 1'b0;
        #1;
        checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL reset_prdata got %h want 00", prdata); end
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", pready); end
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL reset_active got %h want 00", interrupt_active); end
        tick(2);
        irq_in = 8'h00;
        tick(1);
        presetn = 1'b1;
        tick(LAT + 1);
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL post_reset_active got %h want 00", interrupt_active); end
    endtask

    task automatic test_apb();
        apb_write(2'd0, 8'hA5);
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL apb_wr_pready got %b want 1", pready); end
        tick(1);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL apb_wr_pready_low got %b want 0", pready); end
        apb_write(2'd1, 8'h3C);
        apb_read(2'd0, rd);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL apb_rd_mask got %h want a5", rd); end
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL apb_rd_pready got %b want 1", pready); end
        tick(1);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL apb_rd_pready_low got %b want 0", pready); end
        apb_read(2'd1, rd);
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL apb_rd_mode got %h want 3c", rd); end
        irq_in = 8'h81;
        tick(LAT);
        apb_write(2'd3, 8'hFF);
        apb_read(2'd3, rd);
        checks++; if (rd !== 8'h81) begin errors++; $display("FAIL apb_rd_raw got %h want 81", rd); end
        irq_in = 8'h00;
        tick(LAT + 1);
    endtask

    task automatic test_edge_service();
        apb_write(2'd0, 8'hFF);
        apb_write(2'd1, 8'hFF);
        irq_in = 8'h20;
        tick(LAT - 1);
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL edge_early got %h want 00", interrupt_active); end
        tick(1);
        checks++; if (interrupt_active !== 8'h20) begin errors++; $display("FAIL edge_set got %h want 20", interrupt_active); end
        irq_in = 8'h00;
        tick(3);
        checks++; if (interrupt_active !== 8'h20) begin errors++; $display("FAIL edge_persist got %h want 20", interrupt_active); end
        service(3'd5);
        tick(1);
        service_off();
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL edge_service_clr got %h want 00", interrupt_active); end
    endtask

    task automatic test_set_beats_clear();
        irq_in = 8'h04;
        tick(LAT - 1);
        service(3'd2);
        tick(1);
        service_off();
        checks++; if (interrupt_active !== 8'h04) begin errors++; $display("FAIL set_wins got %h want 04", interrupt_active); end
        tick(1);
        checks++; if (interrupt_active !== 8'h04) begin errors++; $display("FAIL set_wins_hold got %h want 04", interrupt_active); end
        irq_in = 8'h00;
        service(3'd2);
        tick(1);
        service_off();
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL set_wins_clear got %h want 00", interrupt_active); end
        tick(LAT);
    endtask

    task automatic test_dual_clear();
        irq_in = 8'h42;
        tick(2);
        irq_in = 8'h00;
        tick(LAT);
        checks++; if (interrupt_active !== 8'h42) begin errors++; $display("FAIL dual_set got %h want 42", interrupt_active); end
        service(3'd1);
        apb_write(2'd2, 8'h40);
        service_off();
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL dual_clear got %h want 00", interrupt_active); end
    endtask

    task automatic test_level();
        apb_write(2'd1, 8'h00);
        apb_write(2'd0, 8'h01);
        irq_in = 8'h01;
        tick(LAT);
        checks++; if (interrupt_active !== 8'h01) begin errors++; $display("FAIL level_set got %h want 01", interrupt_active); end
        service(3'd0);
        tick(1);
        service_off();
        checks++; if (interrupt_active !== 8'h01) begin errors++; $display("FAIL level_svc got %h want 01", interrupt_active); end
        apb_write(2'd2, 8'h01);
        checks++; if (interrupt_active !== 8'h01) begin errors++; $display("FAIL level_w1c got %h want 01", interrupt_active); end
        irq_in = 8'h00;
        tick(LAT - 1);
        checks++; if (interrupt_active !== 8'h01) begin errors++; $display("FAIL level_drop_early got %h want 01", interrupt_active); end
        tick(1);
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL level_drop got %h want 00", interrupt_active); end
    endtask

    task automatic test_mode_switch();
        irq_in = 8'h10;
        tick(LAT);
        apb_read(2'd2, rd);
        checks++; if (rd !== 8'h10) begin errors++; $display("FAIL mode_lvl_pend got %h want 10", rd); end
        apb_write(2'd1, 8'h10);
        apb_read(2'd2, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mode_to_edge_clr got %h want 00", rd); end
        irq_in = 8'h00;
        tick(LAT);
    endtask

    task automatic test_masking();
        apb_write(2'd1, 8'hFF);
        apb_write(2'd0, 8'h00);
        irq_in = 8'h08;
        tick(LAT);
        irq_in = 8'h00;
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL mask_off got %h want 00", interrupt_active); end
        apb_read(2'd2, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL mask_pend got %h want 08", rd); end
        apb_write(2'd0, 8'h08);
        checks++; if (interrupt_active !== 8'h08) begin errors++; $display("FAIL mask_on got %h want 08", interrupt_active); end
        apb_write(2'd2, 8'h08);
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL mask_w1c got %h want 00", interrupt_active); end
    endtask

    task automatic test_reset_midop();
        apb_write(2'd0, 8'hFF);
        irq_in = 8'h02;
        tick(LAT);
        checks++; if (interrupt_active !== 8'h02) begin errors++; $display("FAIL midrst_pre got %h want 02", interrupt_active); end
        #2 presetn = 1'b0;
        #1;
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL midrst_active got %h want 00", interrupt_active); end
        tick(1);
        presetn = 1'b1;
        tick(LAT + 1);
        apb_read(2'd2, rd);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL midrst_level_pend got %h want 02", rd); end
        checks++; if (interrupt_active !== 8'h00) begin errors++; $display("FAIL midrst_masked got %h want 00", interrupt_active); end
        irq_in = 8'h00;
    endtask

    initial begin
        test_reset();
        test_apb();
        test_edge_service();
        test_set_beats_clear();
        test_dual_clear();
        test_level();
        test_mode_switch();
        test_masking();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
